mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-master arbiter for the data-memory bus that feeds `master_memory_map` (RAM + UART slaves). Master 0 is the core MEM stage; master 1 is a secondary bus master such as a UART program loader or debug port. The block serializes single-word accesses with round-robin fairness, supports a bounded lock for master 1 and rejects misaligned addresses. It also produces a stall request for the core pipeline while master 0 waits.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: master/slave address width.
- `DATA_WIDTH`, 32: data width.
- `MAX_HOLD`, 4: max consecutive locked grants to M1 while M0 requests (≥1).

Ports:
- Reset is asynchronous and active-high.
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `m0_req`, `m1_req`  in  1  access request; held until the matching `mX_done`.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read.
- `m0_addr`, `m1_addr`  in  ADDR_WIDTH  byte address.
- `m0_wdata`, `m1_wdata`  in  DATA_WIDTH  write data.
- `m1_lock`  in  1  M1 requests back-to-back ownership.
- `m0_gnt`, `m1_gnt`  out  1  one-cycle pulse, slave access in progress for that master.
- `m0_done`, `m1_done`  out  1  one-cycle completion pulse.
- `m0_err`, `m1_err`  out  1  qualifies `done`: misaligned, access suppressed.
- `m0_rdata`, `m1_rdata`  out  DATA_WIDTH  read data; valid with `done` on a read, held until the next read done.
- `m0_stall`  out  1  `m0_req & ~m0_done` (combinational), to pipeline stall logic.
- `s_we`, `s_re`  out  1  to `master_memory_map` `we`/`re`.
- `s_addr`  out  ADDR_WIDTH  slave address.
- `s_wdata`  out  DATA_WIDTH  slave write data.
- `s_rdata`  in  DATA_WIDTH  slave read data, valid in the cycle `s_re` is high.

## Operation
- States: IDLE, ACCESS, RESP.
- **IDLE:**
  - If no request, stay in IDLE.
  - Otherwise pick a winner and latch its `we`, `addr` and `wdata` into internal registers. Register `owner`, then go to ACCESS.
- **Winner selection, in priority order:**
  1. Lock rule: `last` = 1 and `m1_lock` & `m1_req` and (`hold_cnt` < `MAX_HOLD` or `!m0_req`) → M1.
  2. Single requester → that master.
  3. Both requesting → the master ≠ `last` (round-robin).
- **hold_cnt:**
  - Increments when M1 wins via the lock rule while `m0_req` = 1, saturating at `MAX_HOLD`.
  - Clears whenever M0 wins.
- **ACCESS** (exactly one cycle):
  - `mX_gnt` = 1 for the owner.
  - If latched `addr[1:0]` = 0: drive `s_addr`/`s_wdata` from the latches and assert `s_we` = latched we, `s_re` = ~latched we. Capture `s_rdata` on reads.
  - If `addr[1:0]` ≠ 0: no strobe, and set the error flag.
  - `last` ← owner. Go to RESP.
- **RESP** (one cycle): `mX_done` = 1 for the owner; `mX_err` = error flag; rdata register is valid on reads. Go to IDLE.
- **Outputs when inactive:**
  - `s_we`/`s_re` = 0 outside ACCESS.
  - `s_addr`/`s_wdata` hold the last latched values.
- A master whose req drops before its grant is simply not served. A drop after grant is ignored, and the transaction completes.
- **Reset values:**
  - State IDLE, `owner` = 0, `last` = 1 (M0 wins the first tie), `hold_cnt` = 0, error flag 0.
  - All `gnt`/`done`/`err`/`s_we`/`s_re` = 0; `s_addr`, `s_wdata` and both `rdata` = 0.
- **Reset mid-transaction:** strobes drop asynchronously and no `done` is issued. The master re-requests after reset.

## Timing
- Request sampled in IDLE at edge T; ACCESS in cycle T+1 (`gnt`, `s_we`/`s_re`); RESP in T+2 (`done`, `rdata`); IDLE in T+3.
- Fixed latency of 3 cycles from IDLE sample to IDLE. Throughput is one access per 3 cycles.
- A request arriving during ACCESS/RESP waits for the next IDLE. Both requesters are evaluated there.
- `s_rdata` must be valid in the same cycle `s_re` is high (combinational slave read). It is registered at the end of ACCESS.
- Simultaneous `m0_req` and `m1_req` rising in IDLE after reset: M0 served first, then M1 at T+3.
- `m0_stall` falls in the same cycle `m0_done` rises.

## Test plan
- **Single M0 write:** M0 write addr 0x10, data 0xDEADBEEF.
  - Cycle+1: `s_we` = 1, `s_addr` = 0x10. Cycle+2: `m0_done` = 1, `m0_err` = 0.
  - A subsequent read of 0x10 returns `m0_rdata` = 0xDEADBEEF with `done`.
- **Contention round-robin:** both hold reads continuously from reset → grant order M0, M1, M0, M1, with `done`s 3 cycles apart.
- **Lock bound:** `MAX_HOLD` = 4, M1 locked and M0 requesting after an M1 grant → M1 granted 4 more times, then M0. `hold_cnt` returns to 0.
- **Lock with M0 idle:** M1 locked alone for 10 accesses → all granted to M1, with no M0 `gnt`.
- **Misaligned:** M1 read at 0x13 → no `s_re`/`s_we` pulse; `m1_done` = `m1_err` = 1 at T+2; `m1_rdata` unchanged.
- **Reset mid-access:** assert `rst` during ACCESS → `s_we` drops immediately with no `done`. After release, state is IDLE and a pending M0 req is served at T+1.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two data-memory masters, the arbiter and the
// master_memory_map slave port. The arbiter uses the slave modport; the
// masters/slave environment uses the master modport.
interface mem_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  m0_req;
    logic                  m1_req;
    logic                  m0_we;
    logic                  m1_we;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic                  m1_lock;
    logic                  m0_gnt;
    logic                  m1_gnt;
    logic                  m0_done;
    logic                  m1_done;
    logic                  m0_err;
    logic                  m1_err;
    logic [DATA_WIDTH-1:0] m0_rdata;
    logic [DATA_WIDTH-1:0] m1_rdata;
    logic                  m0_stall;
    logic                  s_we;
    logic                  s_re;
    logic [ADDR_WIDTH-1:0] s_addr;
    logic [DATA_WIDTH-1:0] s_wdata;
    logic [DATA_WIDTH-1:0] s_rdata;

    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
               m0_wdata, m1_wdata, m1_lock, s_rdata,
        output m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err,
               m0_rdata, m1_rdata, m0_stall, s_we, s_re, s_addr, s_wdata
    );

    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
               m0_wdata, m1_wdata, m1_lock, s_rdata,
        input  m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err,
               m0_rdata, m1_rdata, m0_stall, s_we, s_re, s_addr, s_wdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master data-memory bus arbiter. Serializes single-word accesses
// (IDLE -> ACCESS -> RESP), round-robin between the core MEM stage (M0)
// and a secondary master (M1), with a bounded back-to-back lock for M1
// and rejection of misaligned addresses.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_HOLD   = 4
) (
    input logic              clk,
    input logic              rst,
    mem_bus_arbiter_if.slave bus
);
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state;
    logic                  owner;
    logic                  last;
    logic [HW-1:0]         hold_cnt;
    logic                  err_flag;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  m0_gnt_q, m1_gnt_q;
    logic                  m0_done_q, m1_done_q;
    logic                  m0_err_q, m1_err_q;
    logic [DATA_WIDTH-1:0] m0_rdata_q, m1_rdata_q;
    logic                  s_we_q, s_re_q;

    logic                  lock_win;
    logic                  win;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_aligned;

    // Winner selection: lock rule first, then single requester, then round-robin.
    always_comb begin
        lock_win = last && bus.m1_lock && bus.m1_req &&
                   ((hold_cnt < HW'(MAX_HOLD)) || !bus.m0_req);
        win = 1'b0;
        if (lock_win) begin
            win = 1'b1;
        end else if (bus.m0_req && bus.m1_req) begin
            win = ~last;
        end else begin
            win = bus.m1_req;
        end
        sel_we      = win ? bus.m1_we    : bus.m0_we;
        sel_addr    = win ? bus.m1_addr  : bus.m0_addr;
        sel_wdata   = win ? bus.m1_wdata : bus.m0_wdata;
        sel_aligned = (sel_addr[1:0] == 2'b00);
    end

    // Transaction sequencer with registered grant, strobe and completion outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last       <= 1'b1;
            hold_cnt   <= '0;
            err_flag   <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            m0_gnt_q   <= 1'b0;
            m1_gnt_q   <= 1'b0;
            m0_done_q  <= 1'b0;
            m1_done_q  <= 1'b0;
            m0_err_q   <= 1'b0;
            m1_err_q   <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            s_we_q     <= 1'b0;
            s_re_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.m0_req || bus.m1_req) begin
                        owner    <= win;
                        we_q     <= sel_we;
                        addr_q   <= sel_addr;
                        wdata_q  <= sel_wdata;
                        err_flag <= ~sel_aligned;
                        m0_gnt_q <= ~win;
                        m1_gnt_q <= win;
                        s_we_q   <= sel_aligned & sel_we;
                        s_re_q   <= sel_aligned & ~sel_we;
                        if (!win) begin
                            hold_cnt <= '0;
                        end else if (lock_win && bus.m0_req &&
                                     (hold_cnt < HW'(MAX_HOLD))) begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    m0_gnt_q <= 1'b0;
                    m1_gnt_q <= 1'b0;
                    s_we_q   <= 1'b0;
                    s_re_q   <= 1'b0;
                    last     <= owner;
                    if (!err_flag && !we_q) begin
                        if (owner) begin
                            m1_rdata_q <= bus.s_rdata;
                        end else begin
                            m0_rdata_q <= bus.s_rdata;
                        end
                    end
                    m0_done_q <= ~owner;
                    m1_done_q <= owner;
                    m0_err_q  <= ~owner & err_flag;
                    m1_err_q  <= owner & err_flag;
                    state     <= RESP;
                end
                RESP: begin
                    m0_done_q <= 1'b0;
                    m1_done_q <= 1'b0;
                    m0_err_q  <= 1'b0;
                    m1_err_q  <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.m0_gnt   = m0_gnt_q;
    assign bus.m1_gnt   = m1_gnt_q;
    assign bus.m0_done  = m0_done_q;
    assign bus.m1_done  = m1_done_q;
    assign bus.m0_err   = m0_err_q;
    assign bus.m1_err   = m1_err_q;
    assign bus.m0_rdata = m0_rdata_q;
    assign bus.m1_rdata = m1_rdata_q;
    assign bus.s_we     = s_we_q;
    assign bus.s_re     = s_re_q;
    assign bus.s_addr   = addr_q;
    assign bus.s_wdata  = wdata_q;
    assign bus.m0_stall = bus.m0_req & ~m0_done_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_mem_bus_arbiter;
    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Combinational-read slave memory, 16 words at byte addresses 0..63.
    logic [31:0] slave_mem [16] = '{default: 32'h0};
    assign bus.s_rdata = slave_mem[bus.s_addr[5:2]];

    // Slave write port.
    always @(posedge clk) begin
        if (bus.s_we) slave_mem[bus.s_addr[5:2]] <= bus.s_wdata;
    end

    int checks = 0;
    int failures = 0;

    // Transaction-level model state.
    int          edge_no = 0;
    bit          have_txn = 0;
    int          t_dec = 0;
    bit          tx_owner, tx_we;
    logic [31:0] tx_addr, tx_wdata;
    bit          m_last = 1;
    int          m_hold = 0;
    logic [31:0] exp_rdata [2] = '{32'h0, 32'h0};
    logic [31:0] model_mem [16] = '{default: 32'h0};
    bit          g0 = 0, g1 = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelEdge();
        bit lockw, w;
        if (rst) begin
            have_txn  = 0;
            m_last    = 1;
            m_hold    = 0;
            exp_rdata = '{32'h0, 32'h0};
            return;
        end
        edge_no++;
        if (have_txn && edge_no == t_dec + 1 && tx_addr[1:0] == 2'b00) begin
            if (tx_we) model_mem[tx_addr[5:2]] = tx_wdata;
            else       exp_rdata[tx_owner] = model_mem[tx_addr[5:2]];
        end
        if (have_txn && edge_no >= t_dec + 3) have_txn = 0;
        if (!have_txn && (bus.m0_req || bus.m1_req)) begin
            lockw = m_last && bus.m1_lock && bus.m1_req && (m_hold < MAX_HOLD || !bus.m0_req);
            if (lockw) begin
                w = 1;
                if (bus.m0_req && m_hold < MAX_HOLD) m_hold++;
            end else if (bus.m0_req && bus.m1_req) begin
                w = !m_last;
            end else begin
                w = bus.m1_req;
            end
            if (!w) m_hold = 0;
            m_last   = w;
            have_txn = 1;
            t_dec    = edge_no;
            tx_owner = w;
            tx_we    = w ? bus.m1_we : bus.m0_we;
            tx_addr  = w ? bus.m1_addr : bus.m0_addr;
            tx_wdata = w ? bus.m1_wdata : bus.m0_wdata;
        end
    endtask

    task automatic compareAll();
        bit gnt_now, done_now, aligned;
        gnt_now  = have_txn && edge_no == t_dec;
        done_now = have_txn && edge_no == t_dec + 1;
        aligned  = have_txn && tx_addr[1:0] == 2'b00;
        checkOutput("m0_gnt", bus.m0_gnt, gnt_now && !tx_owner);
        checkOutput("m1_gnt", bus.m1_gnt, gnt_now && tx_owner);
        checkOutput("m0_done", bus.m0_done, done_now && !tx_owner);
        checkOutput("m1_done", bus.m1_done, done_now && tx_owner);
        checkOutput("m0_err", bus.m0_err, done_now && !tx_owner && !aligned);
        checkOutput("m1_err", bus.m1_err, done_now && tx_owner && !aligned);
        checkOutput("s_we", bus.s_we, gnt_now && aligned && tx_we);
        checkOutput("s_re", bus.s_re, gnt_now && aligned && !tx_we);
        if (gnt_now && aligned) begin
            checkOutput("s_addr", bus.s_addr, tx_addr);
            if (tx_we) checkOutput("s_wdata", bus.s_wdata, tx_wdata);
        end
        checkOutput("m0_rdata", bus.m0_rdata, exp_rdata[0]);
        checkOutput("m1_rdata", bus.m1_rdata, exp_rdata[1]);
        checkOutput("m0_stall", bus.m0_stall, bus.m0_req && !(done_now && !tx_owner));
    endtask

    task automatic step();
        @(posedge clk);
        modelEdge();
        #1;
        compareAll();
    endtask

    task automatic setM0(input bit req, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata);
        bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
    endtask

    task automatic setM1(input bit req, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit lock);
        bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
        bus.m1_lock = lock;
    endtask

    task automatic doReset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] randAddr();
        logic [31:0] a;
        if ($urandom_range(7) == 0) a = 32'($urandom_range(63));
        else                        a = {26'h0, 4'($urandom_range(15)), 2'b00};
        return a;
    endfunction

    task automatic applyStimulus();
        if (bus.m0_req) begin
            if (bus.m0_gnt) g0 = 1;
            if (bus.m0_done) begin
                bus.m0_req = 0; g0 = 0;
            end else if (!g0 && $urandom_range(15) == 0) begin
                bus.m0_req = 0;
            end
        end else if ($urandom_range(1) == 1) begin
            setM0(1, 1'($urandom_range(1)), randAddr(), $urandom);
        end
        if (bus.m1_req) begin
            if (bus.m1_gnt) g1 = 1;
            if (bus.m1_done) begin
                bus.m1_req = 0; g1 = 0;
            end else if (!g1 && $urandom_range(15) == 0) begin
                bus.m1_req = 0;
            end
        end else if ($urandom_range(1) == 1) begin
            setM1(1, 1'($urandom_range(1)), randAddr(), $urandom, 1'($urandom_range(1)));
        end
    endtask

    int gq_owner[$];
    int gq_cyc[$];

    task automatic recordGrants(input int cycles);
        gq_owner.delete();
        gq_cyc.delete();
        for (int c = 0; c < cycles; c++) begin
            step();
            if (bus.m0_gnt) begin gq_owner.push_back(0); gq_cyc.push_back(c); end
            if (bus.m1_gnt) begin gq_owner.push_back(1); gq_cyc.push_back(c); end
        end
    endtask

    initial begin
        int exp_seq [7];
        int n0, n1;
        rst = 1'b1;
        setM0(0, 0, 32'h0, 32'h0);
        setM1(0, 0, 32'h0, 32'h0, 0);
        step();
        step();
        checkOutput("reset_s_addr", bus.s_addr, 32'h0);
        checkOutput("reset_s_wdata", bus.s_wdata, 32'h0);
        checkOutput("reset_m0_rdata", bus.m0_rdata, 32'h0);
        rst = 1'b0;

        $display("[TB] single M0 write then read");
        setM0(1, 1, 32'h10, 32'hDEADBEEF);
        step();
        checkOutput("wr_s_we", bus.s_we, 1);
        checkOutput("wr_s_addr", bus.s_addr, 32'h10);
        checkOutput("wr_m0_gnt", bus.m0_gnt, 1);
        step();
        checkOutput("wr_m0_done", bus.m0_done, 1);
        checkOutput("wr_m0_err", bus.m0_err, 0);
        setM0(0, 0, 32'h0, 32'h0);
        step();
        setM0(1, 0, 32'h10, 32'h0);
        step();
        checkOutput("rd_s_re", bus.s_re, 1);
        step();
        checkOutput("rd_m0_done", bus.m0_done, 1);
        checkOutput("rd_m0_rdata", bus.m0_rdata, 32'hDEADBEEF);
        setM0(0, 0, 32'h0, 32'h0);
        step();

        $display("[TB] misaligned M1 read");
        setM1(1, 0, 32'h13, 32'h0, 0);
        step();
        checkOutput("mis_s_re", bus.s_re, 0);
        checkOutput("mis_s_we", bus.s_we, 0);
        checkOutput("mis_m1_gnt", bus.m1_gnt, 1);
        step();
        checkOutput("mis_m1_done", bus.m1_done, 1);
        checkOutput("mis_m1_err", bus.m1_err, 1);
        checkOutput("mis_m1_rdata", bus.m1_rdata, 32'h0);
        setM1(0, 0, 32'h0, 32'h0, 0);
        step();

        $display("[TB] contention round-robin");
        doReset();
        setM0(1, 0, 32'h10, 32'h0);
        setM1(1, 0, 32'h14, 32'h0, 0);
        recordGrants(12);
        setM0(0, 0, 32'h0, 32'h0);
        setM1(0, 0, 32'h0, 32'h0, 0);
        checkOutput("rr_count", gq_owner.size(), 4);
        for (int i = 0; i < 4 && i < gq_owner.size(); i++) begin
            checkOutput("rr_owner", gq_owner[i], i % 2);
            if (i > 0) checkOutput("rr_spacing", gq_cyc[i] - gq_cyc[i-1], 3);
        end
        step(); step(); step();

        $display("[TB] lock bound");
        doReset();
        setM1(1, 0, 32'h18, 32'h0, 1);
        step();
        checkOutput("lock_first_m1_gnt", bus.m1_gnt, 1);
        setM0(1, 0, 32'h1C, 32'h0);
        recordGrants(21);
        setM0(0, 0, 32'h0, 32'h0);
        setM1(0, 0, 32'h0, 32'h0, 0);
        exp_seq = '{1, 1, 1, 1, 0, 1, 1};
        checkOutput("lock_count", gq_owner.size(), 7);
        for (int i = 0; i < 7 && i < gq_owner.size(); i++) begin
            checkOutput("lock_owner", gq_owner[i], exp_seq[i]);
        end
        step(); step(); step();

        $display("[TB] lock with M0 idle");
        doReset();
        setM1(1, 1, 32'h20, 32'h12345678, 1);
        recordGrants(30);
        setM1(0, 0, 32'h0, 32'h0, 0);
        n0 = 0; n1 = 0;
        foreach (gq_owner[i]) begin
            if (gq_owner[i] == 0) n0++; else n1++;
        end
        checkOutput("lockalone_m1_grants", n1, 10);
        checkOutput("lockalone_m0_grants", n0, 0);
        step(); step(); step();

        $display("[TB] reset mid-access");
        setM0(1, 1, 32'h24, 32'hCAFEF00D);
        step();
        checkOutput("rma_s_we_before", bus.s_we, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rma_s_we_async", bus.s_we, 0);
        checkOutput("rma_m0_gnt_async", bus.m0_gnt, 0);
        step();
        checkOutput("rma_no_done", bus.m0_done, 0);
        rst = 1'b0;
        step();
        checkOutput("rma_regrant", bus.m0_gnt, 1);
        checkOutput("rma_s_we_again", bus.s_we, 1);
        step();
        checkOutput("rma_done", bus.m0_done, 1);
        setM0(0, 0, 32'h0, 32'h0);
        step();

        $display("[TB] randomized traffic");
        g0 = 0; g1 = 0;
        for (int c = 0; c < 1500; c++) begin
            step();
            applyStimulus();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
